// File: rtl/alu_seq.sv
// alu_seq: handshaked, tagged ALU with an iterative shift-add multiplier.
// One operation in flight: single-cycle ops land in HOLD on the accepting
// edge, MUL iterates WIDTH edges in the MUL state before landing in HOLD.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef logic [WIDTH-1:0] word_t;
  localparam word_t WIDTH_V = word_t'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic             rdy_q;      // low through reset and the first cycle after it
  word_t            acc_q, mcand_q, mplier_q, acc_next;
  logic [CNT_W-1:0] cnt_q;

  word_t            alu_res, sra_res;
  logic             alu_err;
  logic             shift_big;
  logic [SH_W-1:0]  shamt;
  logic             is_mul;
  logic             accept;

  // Shift helpers: any amount >= WIDTH saturates, otherwise the low bits suffice.
  assign shift_big = (in_b >= WIDTH_V);
  assign shamt     = in_b[SH_W-1:0];
  assign sra_res   = $signed(in_a) >>> shamt;

  assign is_mul    = (in_op == OP_MUL) && (MUL_EN != 0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle result and illegal-opcode detection for the request on the inputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    alu_res = '0;
    alu_err = 1'b0;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLL:  alu_res = shift_big ? '0 : (in_a << shamt);
      OP_SRL:  alu_res = shift_big ? '0 : (in_a >> shamt);
      OP_SRA:  alu_res = shift_big ? {WIDTH{in_a[WIDTH-1]}} : sra_res;
      OP_MUL:  alu_err = (MUL_EN == 0);
      default: alu_err = 1'b1;
    endcase
  end

  // Accept in IDLE, or in HOLD when the held result retires on the same edge.
  always_comb begin
    in_ready = 1'b0;
    if (rdy_q) begin
      case (state_q)
        S_IDLE:  in_ready = 1'b1;
        S_HOLD:  in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = is_mul ? S_MUL : S_HOLD;
      end
      S_MUL: begin
        if (cnt_q == '0) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (accept) state_d = is_mul ? S_MUL : S_HOLD;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Result registers and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      out_x    <= '0;
      out_tag  <= '0;
      out_err  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        out_tag <= in_tag;
        if (is_mul) begin
          mcand_q  <= in_a;
          mplier_q <= in_b;
          acc_q    <= '0;
          cnt_q    <= CNT_W'(WIDTH - 1);
          out_err  <= 1'b0;
        end else begin
          out_x   <= alu_res;
          out_err <= alu_err;
        end
      end else if (state_q == S_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == '0) out_x <= acc_next;
      end
    end
  end

endmodule
